// File: rtl/nv_nvdla_sdp_mrdma_pkg.sv
// nv_nvdla_sdp_mrdma_pkg: shared MRDMA egress constants and pointer helper
package nv_nvdla_sdp_mrdma_pkg;
  localparam int MRDMA_EG_PD_W = 256;
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/nv_nvdla_sdp_mrdma_eg_flopram_rwsa_param.sv
// nv_nvdla_sdp_mrdma_eg_flopram_rwsa_param: flop RAM, one sync write port, one comb read port
module nv_nvdla_sdp_mrdma_eg_flopram_rwsa_param #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[wa] <= di;
  assign dout = mem_q[ra];
endmodule

// File: rtl/nv_nvdla_sdp_mrdma_eg_sfifo_param.sv
// nv_nvdla_sdp_mrdma_eg_sfifo_param: flop FIFO with optional empty-bypass for MRDMA egress
module nv_nvdla_sdp_mrdma_eg_sfifo_param
  import nv_nvdla_sdp_mrdma_pkg::*;
#(
  parameter int WIDTH  = MRDMA_EG_PD_W,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] ram_dout;
  logic empty, full, byp, wr_fire, rd_fire, wr_st, rd_st;
  logic unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;
  assign empty   = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign byp     = (BYPASS != 0) && empty;
  assign wr_prdy = !rst && !full;
  assign rd_pvld = !rst && (!empty || (byp && wr_pvld));
  assign rd_pd   = byp ? wr_pd : ram_dout;
  assign count   = count_q;
  assign wr_fire = wr_pvld && wr_prdy;
  assign rd_fire = rd_pvld && rd_prdy;
  // a write consumed straight through the bypass never touches storage
  assign wr_st   = wr_fire && !(byp && rd_fire);
  assign rd_st   = rd_fire && !empty;
  always_comb begin
    wr_ptr_d = wr_st ? AW'(next_ptr(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_st ? AW'(next_ptr(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    count_d  = (wr_st && !rd_st) ? count_q + 1'b1 : (rd_st && !wr_st) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  nv_nvdla_sdp_mrdma_eg_flopram_rwsa_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk (clk),
    .we  (wr_st),
    .wa  (wr_ptr_q),
    .di  (wr_pd),
    .ra  (rd_ptr_q),
    .dout(ram_dout)
  );
endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_eg_sfifo_param.sv
// tb_nv_nvdla_sdp_mrdma_eg_sfifo_param: three FIFO variants driven in lockstep against queue models
module tb_nv_nvdla_sdp_mrdma_eg_sfifo_param;
  localparam int DEP[3] = '{4, 3, 4};
  localparam int BYP[3] = '{1, 1, 0};
  logic clk = 0, rst = 1, wr_pvld = 0, rd_prdy = 0;
  logic [255:0] wr_pd = '0;
  logic [31:0] pwr = '0;
  logic wr_prdy[3], rd_pvld[3];
  logic [255:0] rd_pd[3];
  logic [2:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic [255:0] mq[3][$];
  logic [255:0] out1[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  nv_nvdla_sdp_mrdma_eg_sfifo_param #(.WIDTH(256), .DEPTH(4), .BYPASS(1)) u_d4b1 (
    .clk(clk), .rst(rst), .pwrbus_ram_pd(pwr), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy[0]), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld[0]), .rd_prdy(rd_prdy), .rd_pd(rd_pd[0]), .count(cnt0));
  nv_nvdla_sdp_mrdma_eg_sfifo_param #(.WIDTH(256), .DEPTH(3), .BYPASS(1)) u_d3b1 (
    .clk(clk), .rst(rst), .pwrbus_ram_pd(pwr), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy[1]), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld[1]), .rd_prdy(rd_prdy), .rd_pd(rd_pd[1]), .count(cnt1));
  nv_nvdla_sdp_mrdma_eg_sfifo_param #(.WIDTH(256), .DEPTH(4), .BYPASS(0)) u_d4b0 (
    .clk(clk), .rst(rst), .pwrbus_ram_pd(pwr), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy[2]), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld[2]), .rd_prdy(rd_prdy), .rd_pd(rd_pd[2]), .count(cnt2));
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int cnt_of(input int i);
    return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
  endfunction
  // compare every variant to its queue model, then advance the models across the edge
  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      int sz;
      bit ep, ev, wf, rf;
      sz = mq[i].size();
      ep = !rst && sz != DEP[i];
      ev = !rst && (sz != 0 || (BYP[i] != 0 && wr_pvld));
      chk($sformatf("wr_prdy[%0d]", i), wr_prdy[i], ep);
      chk($sformatf("rd_pvld[%0d]", i), rd_pvld[i], ev);
      if (ev) chk($sformatf("rd_pd[%0d]", i), rd_pd[i], (sz != 0) ? mq[i][0] : wr_pd);
      chk($sformatf("count[%0d]", i), cnt_of(i), sz);
      if (rst) mq[i].delete();
      else begin
        wf = wr_pvld && ep;
        rf = ev && rd_prdy;
        if (i == 1 && rf) out1.push_back(rd_pd[1]);
        if (!(rf && sz == 0)) begin
          if (rf) void'(mq[i].pop_front());
          if (wf) mq[i].push_back(wr_pd);
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    tick();
    wr_pvld = 1; wr_pd = {32{8'hA5}}; rd_prdy = 1;
    tick();
    wr_pvld = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; rd_prdy = 0; wr_pvld = 1;
    for (int k = 1; k <= 5; k++) begin
      wr_pd = 256'(k);
      tick();
    end
    #1;
    chk("fill_count", cnt0, 3'd4);
    chk("fill_prdy", wr_prdy[0], 1'b0);
    chk("fill_head", rd_pd[0], 256'd1);
    wr_pd = 256'd6; rd_prdy = 1;
    tick();
    tick();
    wr_pvld = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; out1.delete();
    wr_pvld = 1; wr_pd = '0; rd_prdy = 0;
    tick();
    rd_prdy = 1;
    for (int k = 1; k <= 9; k++) begin
      wr_pd = 256'(k);
      tick();
    end
    wr_pvld = 0;
    tick();
    tick();
    chk("wrap_len", out1.size(), 10);
    for (int k = 0; k < 10 && k < out1.size(); k++) chk($sformatf("wrap_word%0d", k), out1[k], 256'(k));
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 49) == 0;
      wr_pvld = $urandom_range(0, 3) != 0;
      rd_prdy = $urandom_range(0, 2) != 0;
      wr_pd = {8{$urandom}};
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nv_nvdla_sdp_mrdma_eg_sfifo_param.md
# nv_nvdla_sdp_mrdma_eg_sfifo_param

Parametrised synchronous FIFO for the SDP MRDMA egress datapath. Flop-based storage, valid/ready handshake on both sides, and an optional same-cycle bypass from write to read when the FIFO is empty. It generalises the single-entry flop RAM with write-through read into a configurable width and depth. It sits between the MRDMA read-return unpacker and the egress command/data pipe.

## Interface
- WIDTH, 256, payload bits per entry
- DEPTH, 4, number of entries; any integer ≥ 1, power of two not required
- BYPASS, 1, 1 = when the FIFO is empty, write data is presented on the read side in the same cycle; 0 = every entry is stored first
- CW, $clog2(DEPTH+1), derived width of the occupancy counter

Ports:
- clk  in  1  core clock; every flop is on the rising edge
- rst  in  1  reset; synchronous, active-high
- pwrbus_ram_pd  in  32  RAM power-down bus; ignored, kept for interface compatibility
- wr_pvld  in  1  write valid
- wr_prdy  out  1  write ready
- wr_pd  in  WIDTH  write payload
- rd_pvld  out  1  read valid
- rd_prdy  in  1  read ready
- rd_pd  out  WIDTH  read payload
- count  out  CW  number of stored entries (bypassed words are not counted)

## Operation
- Write fire is wr_pvld & wr_prdy. Read fire is rd_pvld & rd_prdy.
- wr_prdy = !rst & (count != DEPTH). It depends only on registered state; there is no combinational path from rd_prdy.
- rd_pvld:
  - !rst & ((count != 0) | (BYPASS & wr_pvld)).
- rd_pd:
  - When count == 0 and BYPASS = 1: rd_pd = wr_pd.
  - Otherwise: rd_pd = storage[rd_ptr].
  - When rd_pvld = 0, rd_pd is don't-care.
- Bypass case (BYPASS = 1, count == 0, write fire, rd_prdy = 1):
  - The word passes straight through.
  - Nothing is written to storage; pointers and count are unchanged.
- Bypass, read not ready (count == 0, write fire, rd_prdy = 0): the word is stored normally and count becomes 1.
- Write fire, non-bypass case: storage[wr_ptr] <= wr_pd, then wr_ptr advances.
- Read fire from storage: rd_ptr advances.
- Pointer advance: ptr == DEPTH-1 wraps to 0, otherwise ptr+1.
- Count update:
  - +1 for a stored write only.
  - −1 for a stored read only.
  - Unchanged for both together, or for a bypass.
- Full (count == DEPTH): wr_prdy = 0, so a simultaneous read frees the slot but no write is taken that cycle.
- Empty with BYPASS = 0: rd_pvld = 0 even if wr_pvld = 1.
- DEPTH = 1 is legal; the pointers are constant 0.

## Timing
- Reset: while rst = 1, and on the first cycle after its release:
  - count = 0, wr_ptr = 0, rd_ptr = 0.
  - wr_prdy = 0 while rst = 1, and 1 on the first cycle after release.
  - rd_pvld = 0 while rst = 1.
- Storage flops are not reset.
- rst asserted mid-operation discards every stored entry on the next edge.
- Latency:
  - Bypass: 0 cycles (combinational wr_pd → rd_pd).
  - Stored word: visible on rd_pd the cycle after the write edge.
- Throughput: one write and one read per cycle, sustained, when 0 < count < DEPTH.
- Write-to-read combinational paths exist only through the bypass mux (wr_pvld → rd_pvld, wr_pd → rd_pd).

## Structure
- Shared package nv_nvdla_sdp_mrdma_pkg holds:
  - the pointer-wrap function next_ptr(ptr, DEPTH);
  - the default MRDMA egress payload width constant (256).
- Sub-module nv_nvdla_sdp_mrdma_eg_flopram_rwsa_param, with parameters WIDTH and DEPTH:
  - one write port (we, wa, di) and one combinational read port (ra, dout);
  - no reset.
- The FIFO top holds the pointers, count, handshake logic and bypass mux.

## Test plan
- Reset release, DEPTH=4: hold rst 3 cycles, then drop it → count=0, wr_prdy=1 on the first cycle after release; rd_pvld=0 with wr_pvld=0.
- Bypass, BYPASS=1, empty, rd_prdy=1: write 0xA5…A5 → rd_pvld=1 and rd_pd=0xA5…A5 in the same cycle; count stays 0.
- Fill and stall, DEPTH=4, rd_prdy=0: write 1, 2, 3, 4 → count=4 and wr_prdy=0; a 5th wr_pvld is not accepted; rd_pd=1.
- Full with a simultaneous read: count=4, rd_prdy=1, wr_pvld=1 → read 1, no write, count=3; next cycle the write is accepted and count stays 3.
- Wrap-around, DEPTH=3: stream 10 words at 1 write + 1 read per cycle after a one-word prefill → output order 0..9 is preserved and the pointers wrap 2→0 with no loss.
- BYPASS=0, empty, wr_pvld=1, rd_prdy=1 → rd_pvld=0 that cycle; the word appears the next cycle with count=1.
